spi_master_multi: RTL and testbench

Parametrised SPI master, successor to the fixed 8-bit single-slave SPIMaster. Adds configurable word width, a programmable SCLK divider, up to NUM_CS one-hot active-low chip selects, all four CPOL/CPHA modes, and MSB/LSB-first ordering. Reception is full-duplex with a one-cycle result strobe. It sits between the system-side register/command logic and the board-level SPI pins, and runs entirely in the system clock domain.

---
 rtl/spi_master_multi_if.sv | 45 ++++
 rtl/spi_master_multi.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_multi_if.sv
// Pin and command bundle for spi_master_multi; the master modport is the DUT view.
// Carries the optional Loopback input when SPI_LOOPBACK_EN is defined.
interface spi_master_multi_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    // Start/T_Ready: a request is taken on any rising CLK edge where both are high;
    // T_Data/T_CS/mode bits are captured on that edge. R_Valid is a one-cycle strobe
    // with no back-pressure; R_Data holds its value until the next strobe.
    logic              Start;
    logic [DATA_W-1:0] T_Data;
    logic [CS_W-1:0]   T_CS;
    logic              CPOL;
    logic              CPHA;
    logic              LSB_First;
`ifdef SPI_LOOPBACK_EN
    logic              Loopback;
`endif
    logic              T_Ready;
    logic              Busy;
    logic [DATA_W-1:0] R_Data;
    logic              R_Valid;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [NUM_CS-1:0] CS_n;
    logic [1:0]        dbg_state;

    modport master (
        input  Start, T_Data, T_CS, CPOL, CPHA, LSB_First, MISO,
`ifdef SPI_LOOPBACK_EN
        input  Loopback,
`endif
        output T_Ready, Busy, R_Data, R_Valid, SCLK, MOSI, CS_n, dbg_state
    );

    modport slave (
        output Start, T_Data, T_CS, CPOL, CPHA, LSB_First, MISO,
`ifdef SPI_LOOPBACK_EN
        output Loopback,
`endif
        input  T_Ready, Busy, R_Data, R_Valid, SCLK, MOSI, CS_n, dbg_state
    );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: DATA_W-bit words, CLK_DIV half-period divider, NUM_CS one-hot selects,
// all CPOL/CPHA modes, MSB/LSB first. SPI_LOOPBACK_EN adds a Loopback input (MOSI fed back to RX).
module spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 4
) (
    input logic                CLK,
    input logic                Reset,
    spi_master_multi_if.master bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              rx_bit;
    logic              sample_now;
    logic              shift_now;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    // Out-of-range indices decode to no select; the transfer still runs.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (idx == CS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

`ifdef SPI_LOOPBACK_EN
    logic loop_q, loop_d;
    assign rx_bit = loop_q ? mosi_q : bus.MISO;
`else
    assign rx_bit = bus.MISO;
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        r_data_d   = r_data_q;
        r_valid_d  = 1'b0;
        sample_now = 1'b0;
        shift_now  = 1'b0;
`ifdef SPI_LOOPBACK_EN
        loop_d     = loop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sclk_d = bus.CPOL;
                mosi_d = 1'b0;
                cs_n_d = '1;
                if (bus.Start) begin
                    state_d = ST_LEAD;
                    div_d   = '0;
                    edge_d  = '0;
                    tx_d    = bus.T_Data;
                    rx_d    = '0;
                    cpol_d  = bus.CPOL;
                    cpha_d  = bus.CPHA;
                    lsb_d   = bus.LSB_First;
                    cs_n_d  = cs_decode(bus.T_CS);
                    // CPHA=0 slaves sample on the first edge, so the first bit leads CS.
                    mosi_d  = bus.CPHA ? 1'b0 : first_bit(bus.T_Data, bus.LSB_First);
`ifdef SPI_LOOPBACK_EN
                    loop_d  = bus.Loopback;
`endif
                end
            end
            ST_LEAD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (div_q == DIV_LAST) begin
                    div_d      = '0;
                    sclk_d     = ~sclk_q;
                    edge_d     = edge_q + 1'b1;
                    sample_now = cpha_q ? edge_q[0] : ~edge_q[0];
                    shift_now  = cpha_q ? ~edge_q[0] : (edge_q[0] && (edge_q != EDGE_LAST));
                    if (sample_now) begin
                        rx_d = lsb_q ? {rx_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit};
                    end
                    if (shift_now) begin
                        // CPHA=1 presents its first bit on edge 0 without consuming the shifter.
                        if (cpha_q && (edge_q == '0)) begin
                            mosi_d = first_bit(tx_q, lsb_q);
                        end else begin
                            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                            mosi_d = first_bit(tx_d, lsb_q);
                        end
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = ST_TRAIL;
                        edge_d  = '0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_TRAIL: begin
                sclk_d = cpol_q;
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    state_d   = ST_IDLE;
                    cs_n_d    = '1;
                    mosi_d    = 1'b0;
                    r_data_d  = rx_q;
                    r_valid_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            loop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
`ifdef SPI_LOOPBACK_EN
            loop_q    <= loop_d;
`endif
        end
    end

    assign bus.T_Ready   = (state_q == ST_IDLE);
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.R_Data    = r_data_q;
    assign bus.R_Valid   = r_valid_q;
    assign bus.SCLK      = sclk_q;
    assign bus.MOSI      = mosi_q;
    assign bus.CS_n      = cs_n_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: SPI slave model on the pins, expected-result queue, directed + random transfers.
module tb_spi_master_multi;
    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 4;
    localparam int NUM_CS  = 4;
    localparam int CS_W    = 2;
    localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CS_W-1:0]   cs;
        logic              cpol;
        logic              cpha;
        logic              lsb;
        logic              loop;
        logic [DATA_W-1:0] slv;
    } xfer_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_multi_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();
    spi_master_multi #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS)) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    xfer_t pend_q[$];
    int rv_count = 0;

    always @(negedge clk) if (bus.R_Valid === 1'b1) rv_count++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic bit_at(input logic [DATA_W-1:0] w, input logic lsb, input int i);
        return lsb ? w[i] : w[DATA_W-1-i];
    endfunction

    function automatic logic [NUM_CS-1:0] cs_expect(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        if (int'(idx) < NUM_CS) v[idx] = 1'b0;
        return v;
    endfunction

    function automatic xfer_t mk(input logic [DATA_W-1:0] d, input logic [CS_W-1:0] cs,
                                 input logic cpol, input logic cpha, input logic lsb,
                                 input logic lp, input logic [DATA_W-1:0] s);
        xfer_t x;
        x.data = d; x.cs = cs; x.cpol = cpol; x.cpha = cpha; x.lsb = lsb; x.slv = s;
`ifdef SPI_LOOPBACK_EN
        x.loop = lp;
`else
        x.loop = 1'b0 & lp;
`endif
        return x;
    endfunction

    // SPI slave model: frames on Busy, shifts/samples by SPI mode rules on observed SCLK edges.
    xfer_t cur;
    logic  busy_prev = 1'b0;
    logic  sclk_prev = 1'b0;
    logic  slv_active = 1'b0;
    int    slv_edges = 0;
    int    slv_nout = 0;
    int    slv_nin = 0;
    logic [DATA_W-1:0] slv_mosi = '0;
    logic  slv_cs_ok = 1'b0;
    logic  slv_idle_ok = 1'b0;
    logic  slv_dir_ok = 1'b0;
    logic  miso = 1'b0;
    assign bus.MISO = miso;

    always @(negedge clk) begin
        if (rst) begin
            slv_active = 1'b0;
            miso = 1'b0;
        end else if (bus.Busy === 1'b1 && !busy_prev) begin
            if (pend_q.size() > 0) cur = pend_q.pop_front();
            slv_active  = 1'b1;
            slv_edges   = 0;
            slv_nout    = 0;
            slv_nin     = 0;
            slv_mosi    = '0;
            slv_cs_ok   = (bus.CS_n === cs_expect(cur.cs));
            slv_idle_ok = (bus.SCLK === cur.cpol);
            slv_dir_ok  = 1'b1;
            if (!cur.cpha) begin
                miso = bit_at(cur.slv, cur.lsb, 0);
                slv_nout = 1;
            end
        end else if (slv_active && bus.Busy === 1'b1) begin
            if (bus.CS_n !== cs_expect(cur.cs)) slv_cs_ok = 1'b0;
            if (bus.SCLK !== sclk_prev) begin
                if ((slv_edges % 2 == 0) != cur.cpha) begin
                    if (bus.SCLK !== ~(cur.cpol ^ cur.cpha)) slv_dir_ok = 1'b0;
                    if (slv_nin < DATA_W) begin
                        slv_mosi[cur.lsb ? slv_nin : DATA_W - 1 - slv_nin] = bus.MOSI;
                        slv_nin++;
                    end
                end else if (slv_nout < DATA_W) begin
                    miso = bit_at(cur.slv, cur.lsb, slv_nout);
                    slv_nout++;
                end
                slv_edges++;
            end
        end
        busy_prev = (bus.Busy === 1'b1) && !rst;
        sclk_prev = bus.SCLK;
    end

    // scoreboard comparisons
    task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic apply_inputs(input xfer_t x);
        bus.T_Data    = x.data;
        bus.T_CS      = x.cs;
        bus.CPOL      = x.cpol;
        bus.CPHA      = x.cpha;
        bus.LSB_First = x.lsb;
`ifdef SPI_LOOPBACK_EN
        bus.Loopback  = x.loop;
`endif
        pend_q.push_back(x);
        exp_q.push_back(x.loop ? x.data : x.slv);
    endtask

    task automatic start_xfer(input xfer_t x);
        @(negedge clk);
        apply_inputs(x);
        bus.Start = 1'b1;
    endtask

    task automatic apply_noise();
        bus.T_Data    = DATA_W'($urandom);
        bus.T_CS      = CS_W'($urandom);
        bus.CPOL      = 1'($urandom);
        bus.CPHA      = 1'($urandom);
        bus.LSB_First = 1'($urandom);
`ifdef SPI_LOOPBACK_EN
        bus.Loopback  = 1'($urandom);
`endif
    endtask

    task automatic check_done(input xfer_t x, input string tag, input int cyc);
        logic [DATA_W-1:0] e;
        chkw({tag, "_latency"}, 32'(cyc), 32'(LAT + 1));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chkw({tag, "_rdata"}, 32'(bus.R_Data), 32'(e));
        chkw({tag, "_mosi_word"}, 32'(slv_mosi), 32'(x.data));
        chkw({tag, "_sclk_edges"}, 32'(slv_edges), 32'(2 * DATA_W));
        chk1({tag, "_cs_during"}, slv_cs_ok, 1'b1);
        chk1({tag, "_sclk_idle"}, slv_idle_ok, 1'b1);
        chk1({tag, "_sample_dir"}, slv_dir_ok, 1'b1);
        chkw({tag, "_cs_released"}, 32'(bus.CS_n), 32'({NUM_CS{1'b1}}));
        chk1({tag, "_tready_done"}, bus.T_Ready, 1'b1);
        chk1({tag, "_sclk_rest"}, bus.SCLK, x.cpol);
        chk1({tag, "_mosi_rest"}, bus.MOSI, 1'b0);
    endtask

    // Called on the first negedge after the accept edge.
    task automatic finish_xfer(input xfer_t x, input string tag);
        int cyc;
        chk1({tag, "_busy"}, bus.Busy, 1'b1);
        chk1({tag, "_tready_busy"}, bus.T_Ready, 1'b0);
        apply_noise();
        cyc = 1;
        while (bus.R_Valid !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_done(x, tag, cyc);
        @(negedge clk);
        chk1({tag, "_rvalid_pulse"}, bus.R_Valid, 1'b0);
    endtask

    task automatic run_xfer(input xfer_t x, input string tag);
        start_xfer(x);
        @(negedge clk);
        bus.Start = 1'b0;
        finish_xfer(x, tag);
    endtask

    // directed sequence
    initial begin
        xfer_t a, b;
        int cyc;
        int rv_before;

        bus.Start     = 1'b0;
        bus.T_Data    = '0;
        bus.T_CS      = '0;
        bus.CPOL      = 1'b1;
        bus.CPHA      = 1'b0;
        bus.LSB_First = 1'b0;
`ifdef SPI_LOOPBACK_EN
        bus.Loopback  = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_tready", bus.T_Ready, 1'b1);
        chk1("rst_busy", bus.Busy, 1'b0);
        chk1("rst_rvalid", bus.R_Valid, 1'b0);
        chkw("rst_rdata", 32'(bus.R_Data), 32'h0);
        chk1("rst_sclk", bus.SCLK, 1'b0);
        chk1("rst_mosi", bus.MOSI, 1'b0);
        chkw("rst_cs_n", 32'(bus.CS_n), 32'({NUM_CS{1'b1}}));
        rst = 1'b0;
        bus.CPOL = 1'b0;
        repeat (2) @(negedge clk);

        run_xfer(mk(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C), "mode0_a5");

        for (int m = 0; m < 4; m++) begin
            run_xfer(mk(8'h96, CS_W'(m), m[1], m[0], 1'b0, 1'b0, 8'h69), $sformatf("mode%0d_96", m));
        end

        run_xfer(mk(8'h01, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80), "lsb_first");

        // back-to-back with Start held, mid-XFER Start pulse and input changes
        a = mk(8'hC3, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5E);
        b = mk(8'h4B, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hD2);
        start_xfer(a);
        @(negedge clk);
        cyc = 1;
        chk1("b2b_busy", bus.Busy, 1'b1);
        repeat (29) begin @(negedge clk); cyc++; end
        bus.Start = 1'b0;
        @(negedge clk);
        cyc++;
        apply_inputs(b);
        bus.Start = 1'b1;
        while (bus.R_Valid !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_done(a, "b2b_first", cyc);
        @(negedge clk);
        bus.Start = 1'b0;
        chk1("b2b_rvalid_drop", bus.R_Valid, 1'b0);
        chkw("b2b_cs_gap", 32'(bus.CS_n), 32'(cs_expect(b.cs)));
        finish_xfer(b, "b2b_second");

        // reset during the third bit of XFER
        a = mk(8'hFF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        start_xfer(a);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (24) @(negedge clk);
        rv_before = rv_count;
        rst = 1'b1;
        @(negedge clk);
        chkw("abort_cs_n", 32'(bus.CS_n), 32'({NUM_CS{1'b1}}));
        chk1("abort_sclk", bus.SCLK, 1'b0);
        chk1("abort_mosi", bus.MOSI, 1'b0);
        chk1("abort_tready", bus.T_Ready, 1'b1);
        chk1("abort_busy", bus.Busy, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        pend_q.delete();
        repeat (100) @(negedge clk);
        chkw("abort_no_rvalid", 32'(rv_count), 32'(rv_before));

        run_xfer(mk(8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h37), "after_abort_ff");

`ifdef SPI_LOOPBACK_EN
        run_xfer(mk(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00), "loop_on");
        run_xfer(mk(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), "loop_off");
`endif

        for (int i = 0; i < 10; i++) begin
            xfer_t r;
            r = mk(DATA_W'($urandom), CS_W'($urandom_range(0, NUM_CS - 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), DATA_W'($urandom));
            run_xfer(r, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
